// File: rtl/ad9826_serial_responder.sv
// ad9826_serial_responder: AD9826 3-wire config port slave with parallel register file.
// Serial inputs are oversampled by clk; all frame decoding runs on synchronized edges.
module ad9826_serial_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [71:0] REG_INIT    = 72'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ad_sclk,
    input  logic        ad_sload,
    input  logic        ad_sdata_i,
    output logic        ad_sdata_o,
    output logic        ad_sdata_oe,
    output logic [71:0] reg_file,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DONE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_s, sload_s, sdata_s;
    logic       sclk_q, sload_q;
    logic       sclk_y, sload_y, sdata_y;
    logic       sclk_rise, sclk_fall, sload_rise, sload_fall;
    logic [3:0] bit_cnt;
    logic [5:0] hdr;
    logic [7:0] sr;
    logic [8:0] shadow;
    logic [2:0] addr;
    logic       in_frame, abort, commit;
    assign sclk_y     = sclk_s[SYNC_STAGES-1];
    assign sload_y    = sload_s[SYNC_STAGES-1];
    assign sdata_y    = sdata_s[SYNC_STAGES-1];
    assign sclk_rise  = sclk_y & ~sclk_q;
    assign sclk_fall  = ~sclk_y & sclk_q;
    assign sload_rise = sload_y & ~sload_q;
    assign sload_fall = ~sload_y & sload_q;
    assign in_frame   = state == HDR || state == WDATA || state == RDATA;
    assign abort      = in_frame && sload_rise;
    assign commit     = state == WDATA && sclk_rise && bit_cnt == 4'd15 && !sload_rise;
    // sload chain resets low so a frame already in progress at reset release never looks like a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s  <= '0;
            sload_s <= '0;
            sdata_s <= '0;
            sclk_q  <= 1'b0;
            sload_q <= 1'b0;
        end else begin
            sclk_s  <= {sclk_s[SYNC_STAGES-2:0], ad_sclk};
            sload_s <= {sload_s[SYNC_STAGES-2:0], ad_sload};
            sdata_s <= {sdata_s[SYNC_STAGES-2:0], ad_sdata_i};
            sclk_q  <= sclk_y;
            sload_q <= sload_y;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sload_fall ? HDR : IDLE;
            HDR:     state_nx = sload_rise ? IDLE :
                                (sclk_rise && bit_cnt == 4'd6) ? (hdr[5] ? RDATA : WDATA) : HDR;
            WDATA:   state_nx = sload_rise ? IDLE : (sclk_rise && bit_cnt == 4'd15) ? DONE : WDATA;
            RDATA:   state_nx = sload_rise ? IDLE : (sclk_rise && bit_cnt == 4'd15) ? DONE : RDATA;
            DONE:    state_nx = sload_rise ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_file    <= REG_INIT;
            ad_sdata_o  <= 1'b0;
            ad_sdata_oe <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 3'd0;
            frame_err   <= 1'b0;
            bit_cnt     <= 4'd0;
            hdr         <= 6'd0;
            sr          <= 8'd0;
            shadow      <= 9'd0;
            addr        <= 3'd0;
        end else begin
            wr_strobe <= commit;
            frame_err <= abort;
            if (state == IDLE && sload_fall) bit_cnt <= 4'd0;
            else if (in_frame && sclk_rise) bit_cnt <= bit_cnt + 4'd1;
            if (state == HDR && sclk_rise) begin
                hdr <= {hdr[4:0], sdata_y};
                if (bit_cnt == 4'd6) begin
                    addr   <= hdr[4:2];
                    shadow <= reg_file[hdr[4:2]*9 +: 9];
                end
            end
            if (state == WDATA && sclk_rise) sr <= {sr[6:0], sdata_y};
            if (commit) begin
                reg_file[addr*9 +: 9] <= {sr, sdata_y};
                wr_addr               <= addr;
            end
            if (state_nx == IDLE) ad_sdata_oe <= 1'b0;
            else if (state == RDATA && sclk_fall) begin
                ad_sdata_oe <= 1'b1;
                ad_sdata_o  <= shadow[8];
                shadow      <= {shadow[7:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_ad9826_serial_responder.sv
// tb_ad9826_serial_responder: directed frames from a behavioural 3-wire master.
module tb_ad9826_serial_responder;
    localparam logic [71:0] INIT = {9'h1F8, 9'h0AB, 9'h15A, 9'h033, 9'h1C4, 9'h0F0, 9'h101, 9'h07E};
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ad_sclk = 1'b0;
    logic        ad_sload = 1'b1;
    logic        ad_sdata_i = 1'b0;
    logic        ad_sdata_o, ad_sdata_oe, wr_strobe, frame_err;
    logic [71:0] reg_file;
    logic [2:0]  wr_addr;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          err_cnt = 0;
    logic [71:0] exp_rf;
    logic [15:0] rd, oem;
    logic        oe_end;

    ad9826_serial_responder #(.SYNC_STAGES(2), .REG_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .ad_sclk(ad_sclk), .ad_sload(ad_sload),
        .ad_sdata_i(ad_sdata_i), .ad_sdata_o(ad_sdata_o), .ad_sdata_oe(ad_sdata_oe),
        .reg_file(reg_file), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sends n sclk pulses (bits past 16 drive 1); rd/oem shift in sdata_o/oe sampled just before each rise.
    task automatic frame(input logic [15:0] w, input int n, input int rst_at,
                         output logic [15:0] rdv, output logic [15:0] oemv, output logic oe_e);
        logic [15:0] sh;
        sh = w;
        rdv = '0;
        oemv = '0;
        ad_sload = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #5;
                chk("rst_oe", {71'd0, ad_sdata_oe}, 72'd0);
                chk("rst_regs", reg_file, INIT);
                rst_n = 1'b1;
            end
            ad_sdata_i = (i < 16) ? sh[15] : 1'b1;
            sh = sh << 1;
            #80;
            if (i < 16) begin
                rdv  = {rdv[14:0], ad_sdata_o};
                oemv = {oemv[14:0], ad_sdata_oe};
            end
            ad_sclk = 1'b1;
            #80;
            ad_sclk = 1'b0;
        end
        #100;
        oe_e = ad_sdata_oe;
        ad_sload = 1'b1;
        #200;
    endtask

    initial begin
        exp_rf = INIT;
        #35;
        chk("reset_regs", reg_file, INIT);
        chk("reset_oe", {71'd0, ad_sdata_oe}, 72'd0);
        chk("reset_o", {71'd0, ad_sdata_o}, 72'd0);
        chk("reset_wrs", {71'd0, wr_strobe}, 72'd0);
        chk("reset_wra", {69'd0, wr_addr}, 72'd0);
        chk("reset_err", {71'd0, frame_err}, 72'd0);
        rst_n = 1'b1;
        #100;

        frame({1'b1, 3'd5, 3'b0, 9'h0}, 16, -1, rd, oem, oe_end);
        chk("rd5_data", {63'd0, rd[8:0]}, 72'h15A);
        chk("rd5_oe_mask", {56'd0, oem}, 72'h01FF);
        chk("rd5_oe_held", {71'd0, oe_end}, 72'd1);
        chk("rd5_oe_off", {71'd0, ad_sdata_oe}, 72'd0);
        chk("rd5_regs", reg_file, INIT);
        chk("rd5_wr_cnt", 72'(wr_cnt), 72'd0);

        frame(16'b0000000_011011000, 16, -1, rd, oem, oe_end);
        exp_rf[8:0] = 9'h0D8;
        chk("wr0_regs", reg_file, exp_rf);
        chk("wr0_wr_cnt", 72'(wr_cnt), 72'd1);
        chk("wr0_wr_addr", {69'd0, wr_addr}, 72'd0);
        chk("wr0_err_cnt", 72'(err_cnt), 72'd0);
        chk("wr0_oe_mask", {56'd0, oem}, 72'd0);

        frame({1'b0, 3'd1, 3'b0, 9'h01E}, 16, -1, rd, oem, oe_end);
        exp_rf[17:9] = 9'h01E;
        chk("wr1_regs", reg_file, exp_rf);
        chk("wr1_wr_addr", {69'd0, wr_addr}, 72'd1);
        frame(16'b1001000_000000000, 16, -1, rd, oem, oe_end);
        chk("rd1_data", {63'd0, rd[8:0]}, 72'h01E);
        chk("rd1_oe_mask", {56'd0, oem}, 72'h01FF);
        chk("rd1_oe_held", {71'd0, oe_end}, 72'd1);
        chk("rd1_oe_off", {71'd0, ad_sdata_oe}, 72'd0);
        chk("rd1_wr_cnt", 72'(wr_cnt), 72'd2);

        frame({1'b0, 3'd3, 3'b0, 9'h155}, 10, -1, rd, oem, oe_end);
        chk("abort_err_cnt", 72'(err_cnt), 72'd1);
        chk("abort_regs", reg_file, exp_rf);
        chk("abort_oe_mask", {56'd0, oem}, 72'd0);
        chk("abort_wr_cnt", 72'(wr_cnt), 72'd2);

        frame({1'b0, 3'd2, 3'b0, 9'h1A5}, 20, -1, rd, oem, oe_end);
        exp_rf[26:18] = 9'h1A5;
        chk("long_regs", reg_file, exp_rf);
        chk("long_wr_cnt", 72'(wr_cnt), 72'd3);
        chk("long_wr_addr", {69'd0, wr_addr}, 72'd2);
        chk("long_err_cnt", 72'(err_cnt), 72'd1);

        frame(16'b1001000_000000000, 16, 9, rd, oem, oe_end);
        exp_rf = INIT;
        chk("rstmid_regs", reg_file, INIT);
        chk("rstmid_oe_held", {71'd0, oe_end}, 72'd0);
        chk("rstmid_err_cnt", 72'(err_cnt), 72'd1);
        chk("rstmid_wr_cnt", 72'(wr_cnt), 72'd3);
        chk("rstmid_wr_addr", {69'd0, wr_addr}, 72'd0);

        frame({1'b0, 3'd4, 3'b0, 9'h0AA}, 16, -1, rd, oem, oe_end);
        exp_rf[44:36] = 9'h0AA;
        chk("post_wr4_regs", reg_file, exp_rf);
        chk("post_wr4_wr_cnt", 72'(wr_cnt), 72'd4);
        chk("post_wr4_wr_addr", {69'd0, wr_addr}, 72'd4);
        frame({1'b1, 3'd4, 3'b0, 9'h0}, 16, -1, rd, oem, oe_end);
        chk("post_rd4_data", {63'd0, rd[8:0]}, 72'h0AA);
        chk("post_rd4_oe_mask", {56'd0, oem}, 72'h01FF);
        chk("post_err_cnt", 72'(err_cnt), 72'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
